// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath (minute and hour counters).
//
// Contents:
//   MIN_MODULUS / HOUR_MODULUS / MIN_WIDTH / HOUR_WIDTH : counter geometry
//   count_state_e : counter state (NORMAL, LOADED)
//   count_op_e    : decoding of the {up, down} enable pair
//   bcd_t / bin_to_bcd : two-digit BCD split used by the optional BCD
//                        outputs (MINUTE_COUNTER_BCD_EN)
package clock_pkg;

    localparam int MIN_MODULUS  = 60;
    localparam int HOUR_MODULUS = 24;
    localparam int MIN_WIDTH    = 6;
    localparam int HOUR_WIDTH   = 5;

    typedef enum logic {
        NORMAL = 1'b0,
        LOADED = 1'b1
    } count_state_e;

    // {up, down}: both asserted together is a deliberate hold.
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_DOWN = 2'b01,
        OP_UP   = 2'b10,
        OP_BOTH = 2'b11
    } count_op_e;

    typedef struct packed {
        logic [2:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Split a 0..59 value into tens/ones. Only called for in-range values.
    function automatic bcd_t bin_to_bcd(input logic [MIN_WIDTH-1:0] val);
        bcd_t r;
        if (val >= 6'd50) begin
            r.tens = 3'd5;
            r.ones = 4'(val - 6'd50);
        end else if (val >= 6'd40) begin
            r.tens = 3'd4;
            r.ones = 4'(val - 6'd40);
        end else if (val >= 6'd30) begin
            r.tens = 3'd3;
            r.ones = 4'(val - 6'd30);
        end else if (val >= 6'd20) begin
            r.tens = 3'd2;
            r.ones = 4'(val - 6'd20);
        end else if (val >= 6'd10) begin
            r.tens = 3'd1;
            r.ones = 4'(val - 6'd10);
        end else begin
            r.tens = 3'd0;
            r.ones = 4'(val);
        end
        return r;
    endfunction

endpackage

// File: rtl/minute_counter_sixty_if.sv
// Signal bundle of the minute counter.
//
// Handshake: there is no valid/ready pair. i_up, i_down and i_load are
// level-sampled strobes taken at every rising edge; o_carryup,
// o_borrowdown and o_load_err are registered single-cycle pulses.
//
// Modports:
//   master : driver side (seconds stage / set logic / bench)
//   slave  : the counter itself
// dbg_state exposes the counter's internal state for observation.
// With MINUTE_COUNTER_BCD_EN defined, o_bcd_tens / o_bcd_ones are added.
interface minute_counter_sixty_if #(
    parameter int WIDTH = clock_pkg::MIN_WIDTH
);
    import clock_pkg::*;

    logic               i_up;
    logic               i_down;
    logic               i_load;
    logic [WIDTH-1:0]   i_load_val;
    logic [WIDTH-1:0]   o_count;
    logic               o_carryup;
    logic               o_borrowdown;
    logic               o_load_err;
    count_state_e       dbg_state;
`ifdef MINUTE_COUNTER_BCD_EN
    logic [2:0]         o_bcd_tens;
    logic [3:0]         o_bcd_ones;
`endif

    modport master (
        output i_up, i_down, i_load, i_load_val,
        input  o_count, o_carryup, o_borrowdown, o_load_err, dbg_state
`ifdef MINUTE_COUNTER_BCD_EN
        , input o_bcd_tens, o_bcd_ones
`endif
    );

    modport slave (
        input  i_up, i_down, i_load, i_load_val,
        output o_count, o_carryup, o_borrowdown, o_load_err, dbg_state
`ifdef MINUTE_COUNTER_BCD_EN
        , output o_bcd_tens, o_bcd_ones
`endif
    );

endinterface

// File: rtl/minute_counter_sixty_bcd.sv
// bcd_digit_pair: tens/ones registers tracking the minute count.
// Present only when MINUTE_COUNTER_BCD_EN is defined.
//
// Ports:
//   i_clk, i_rstn   : clock, synchronous active-low reset
//   i_inc, i_dec    : one-step increment / decrement (mutually exclusive)
//   i_load          : accepted load, i_load_val is in 0..59
//   o_tens, o_ones  : registered digits
`ifdef MINUTE_COUNTER_BCD_EN
module bcd_digit_pair
    import clock_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_inc,
    input  logic                 i_dec,
    input  logic                 i_load,
    input  logic [MIN_WIDTH-1:0] i_load_val,
    output logic [2:0]           o_tens,
    output logic [3:0]           o_ones
);

    logic [2:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    bcd_t       load_bcd;

    always_comb begin
        load_bcd = bin_to_bcd(i_load_val);
        tens_d   = tens_q;
        ones_d   = ones_q;
        if (i_load) begin
            tens_d = load_bcd.tens;
            ones_d = load_bcd.ones;
        end else if (i_inc) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == 3'd5) ? 3'd0 : tens_q + 3'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (i_dec) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = (tens_q == 3'd0) ? 3'd5 : tens_q - 3'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            tens_q <= 3'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign o_tens = tens_q;
    assign o_ones = ones_q;

endmodule
`endif

// File: rtl/minute_counter_sixty.sv
// minute_counter_sixty: mod-MODULUS up/down minute counter with parallel
// load. o_carryup / o_borrowdown feed the hour counter's i_up / i_down.
//
// Ports:
//   i_clk, i_rstn : clock, synchronous active-low reset
//   bus (slave)   : i_up, i_down, i_load, i_load_val in;
//                   o_count, o_carryup, o_borrowdown, o_load_err,
//                   dbg_state out (all registered)
// Optional: MINUTE_COUNTER_BCD_EN adds o_bcd_tens / o_bcd_ones (MODULUS 60).
// Priority per edge: reset > load > count.
module minute_counter_sixty
    import clock_pkg::*;
#(
    parameter int MODULUS = MIN_MODULUS,
    parameter int WIDTH   = MIN_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    minute_counter_sixty_if.slave  bus
);

    localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULUS - 1);

    count_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             load_err_q, load_err_d;

    count_op_e        op;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   count_up_ext;
    logic             load_ok;
    logic             wrap_up;
    logic             wrap_dn;
    logic             step_up;
    logic             step_dn;

    // State register: all flops.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= NORMAL;
            count_q    <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    // Next-state / next-count.
    always_comb begin
        op           = count_op_e'({bus.i_up, bus.i_down});
        count_ext    = {1'b0, count_q};
        count_up_ext = count_ext + 1'b1;
        load_ok      = ({1'b0, bus.i_load_val} <= MAX_EXT);
        state_d      = NORMAL;
        count_d      = count_q;
        wrap_up      = 1'b0;
        wrap_dn      = 1'b0;
        step_up      = 1'b0;
        step_dn      = 1'b0;
        if (bus.i_load) begin
            // Out-of-range load leaves the count alone.
            if (load_ok) begin
                count_d = bus.i_load_val;
                state_d = LOADED;
            end
        end else begin
            case (op)
                OP_UP: begin
                    step_up = 1'b1;
                    if (count_ext == MAX_EXT) begin
                        count_d = '0;
                        wrap_up = 1'b1;
                    end else begin
                        count_d = count_up_ext[WIDTH-1:0];
                    end
                end
                OP_DOWN: begin
                    step_dn = 1'b1;
                    if (count_ext == '0) begin
                        count_d = MAX_EXT[WIDTH-1:0];
                        wrap_dn = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                default: ;  // OP_HOLD, OP_BOTH
            endcase
        end
    end

    // Outputs (registered pulses). The cycle that shows a loaded value
    // (state LOADED) never carries a wrap pulse.
    always_comb begin
        carry_d    = wrap_up && (state_d == NORMAL);
        borrow_d   = wrap_dn && (state_d == NORMAL);
        load_err_d = bus.i_load && !load_ok;
    end

    assign bus.o_count      = count_q;
    assign bus.o_carryup    = carry_q;
    assign bus.o_borrowdown = borrow_q;
    assign bus.o_load_err   = load_err_q;
    assign bus.dbg_state    = state_q;

`ifdef MINUTE_COUNTER_BCD_EN
    bcd_digit_pair u_bcd (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_inc      (step_up),
        .i_dec      (step_dn),
        .i_load     (bus.i_load && load_ok),
        .i_load_val (bus.i_load_val),
        .o_tens     (bus.o_bcd_tens),
        .o_ones     (bus.o_bcd_ones)
    );
`endif

endmodule

// File: tb/tb_minute_counter_sixty.sv
module tb_minute_counter_sixty;

    localparam int MOD = 60;

    logic clk = 1'b0;
    logic rstn;

    minute_counter_sixty_if #(.WIDTH(6)) bus ();

    minute_counter_sixty #(.MODULUS(60), .WIDTH(6)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain modular arithmetic on an integer.
    int m_count  = 0;
    bit m_carry  = 0;
    bit m_borrow = 0;
    bit m_err    = 0;
    bit m_loaded = 0;

    logic [5:0] exp_q[$];

    typedef struct {
        bit rstn;
        bit up;
        bit down;
        bit load;
        int val;
        int e_count;
        bit e_carry;
        bit e_borrow;
        bit e_err;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit up, input bit dn,
                              input bit ld, input int val);
        m_carry  = 0;
        m_borrow = 0;
        m_err    = 0;
        m_loaded = 0;
        if (!r) begin
            m_count = 0;
        end else if (ld) begin
            if (val < MOD) begin
                m_count  = val;
                m_loaded = 1;
            end else begin
                m_err = 1;
            end
        end else if (up && !dn) begin
            m_carry = (m_count == MOD - 1);
            m_count = (m_count + 1) % MOD;
        end else if (dn && !up) begin
            m_borrow = (m_count == 0);
            m_count  = (m_count + MOD - 1) % MOD;
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, settle.
    task automatic step(input bit r, input bit up, input bit dn,
                        input bit ld, input int val);
        rstn           = r;
        bus.i_up       = up;
        bus.i_down     = dn;
        bus.i_load     = ld;
        bus.i_load_val = 6'(val);
        @(posedge clk);
        model_edge(r, up, dn, ld, val);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, int'(bus.o_count), m_count);
        check({tag, "_carry"}, int'(bus.o_carryup), int'(m_carry));
        check({tag, "_borrow"}, int'(bus.o_borrowdown), int'(m_borrow));
        check({tag, "_lderr"}, int'(bus.o_load_err), int'(m_err));
        check({tag, "_state"}, int'(bus.dbg_state), int'(m_loaded));
`ifdef MINUTE_COUNTER_BCD_EN
        check({tag, "_tens"}, int'(bus.o_bcd_tens), m_count / 10);
        check({tag, "_ones"}, int'(bus.o_bcd_ones), m_count % 10);
`endif
    endtask

    initial begin
        rstn           = 1'b0;
        bus.i_up       = 1'b0;
        bus.i_down     = 1'b0;
        bus.i_load     = 1'b0;
        bus.i_load_val = '0;

        //          rstn up dn ld val  count carry borrow err
        vecs[0]  = '{0, 0, 0, 0, 0,    0,    0, 0, 0};
        vecs[1]  = '{1, 0, 1, 0, 0,    59,   0, 1, 0};
        vecs[2]  = '{1, 0, 1, 0, 0,    58,   0, 0, 0};
        vecs[3]  = '{1, 0, 1, 0, 0,    57,   0, 0, 0};
        vecs[4]  = '{1, 0, 1, 0, 0,    56,   0, 0, 0};
        vecs[5]  = '{1, 1, 0, 1, 30,   30,   0, 0, 0};
        vecs[6]  = '{1, 1, 1, 0, 0,    30,   0, 0, 0};
        vecs[7]  = '{1, 1, 1, 0, 0,    30,   0, 0, 0};
        vecs[8]  = '{1, 1, 0, 1, 45,   45,   0, 0, 0};
        vecs[9]  = '{1, 0, 0, 1, 60,   45,   0, 0, 1};
        vecs[10] = '{1, 0, 0, 0, 0,    45,   0, 0, 0};
        vecs[11] = '{1, 0, 0, 1, 59,   59,   0, 0, 0};
        vecs[12] = '{0, 1, 0, 0, 0,    0,    0, 0, 0};
        vecs[13] = '{1, 1, 0, 0, 0,    1,    0, 0, 0};
        vecs[14] = '{1, 0, 1, 1, 63,   1,    0, 0, 1};
        vecs[15] = '{1, 0, 0, 1, 0,    0,    0, 0, 0};
        vecs[16] = '{1, 0, 1, 0, 0,    59,   0, 1, 0};
        vecs[17] = '{1, 1, 0, 0, 0,    0,    1, 0, 0};
        vecs[18] = '{1, 1, 0, 0, 0,    1,    0, 0, 0};

        repeat (2) @(negedge clk);

        // Directed table.
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rstn, vecs[i].up, vecs[i].down, vecs[i].load, vecs[i].val);
            check($sformatf("vec%0d_count", i), int'(bus.o_count), vecs[i].e_count);
            check($sformatf("vec%0d_carry", i), int'(bus.o_carryup), int'(vecs[i].e_carry));
            check($sformatf("vec%0d_borrow", i), int'(bus.o_borrowdown), int'(vecs[i].e_borrow));
            check($sformatf("vec%0d_lderr", i), int'(bus.o_load_err), int'(vecs[i].e_err));
        end

        // Continuous up from reset: 0..59 then 0 with one carry.
        step(0, 0, 0, 0, 0);
        check("cont_reset", int'(bus.o_count), 0);
        for (int i = 1; i <= 60; i++) begin
            step(1, 1, 0, 0, 0);
            check($sformatf("cont_up%0d_count", i), int'(bus.o_count), i % 60);
            check($sformatf("cont_up%0d_carry", i), int'(bus.o_carryup), (i == 60) ? 1 : 0);
        end

        // Both enables held: count frozen at 30, no pulses.
        step(1, 0, 0, 1, 30);
        check("both_load_state", int'(bus.dbg_state), 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 1, 0, 0);
            check($sformatf("both%0d", i), int'(bus.o_count), 30);
            check($sformatf("both%0d_pulse", i),
                  int'(bus.o_carryup) + int'(bus.o_borrowdown), 0);
        end

        // Full up sweep then full down sweep against the model.
        step(0, 0, 0, 0, 0);
        check_model("sweep_rst");
        for (int i = 0; i < 59; i++) begin
            step(1, 1, 0, 0, 0);
            check_model("sweep_up");
        end
        for (int i = 0; i < 59; i++) begin
            step(1, 0, 1, 0, 0);
            check_model("sweep_dn");
        end

`ifdef MINUTE_COUNTER_BCD_EN
        step(1, 0, 0, 1, 37);
        check("bcd_load37_tens", int'(bus.o_bcd_tens), 3);
        check("bcd_load37_ones", int'(bus.o_bcd_ones), 7);
`endif

        // Randomised run against the model through the expected queue.
        for (int i = 0; i < 3000; i++) begin
            bit r, up, dn, ld;
            int val;
            logic [5:0] exp_cnt;
            r   = ($urandom_range(0, 49) != 0);
            ld  = ($urandom_range(0, 9) == 0);
            up  = ($urandom_range(0, 3) != 0);
            dn  = ($urandom_range(0, 2) == 0);
            val = $urandom_range(0, 63);
            step(r, up, dn, ld, val);
            exp_q.push_back(6'(m_count));
            exp_cnt = exp_q.pop_front();
            check("rand_q_count", int'(bus.o_count), int'(exp_cnt));
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
